seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for a multi-digit common-anode 7-segment display. Holds a double-buffered hex value, presents one nibble at a time to the synchronous 7-segment decoder, and drives per-digit enables with a dead-time guard against ghosting. Sits between the register/host logic and the decoder plus the board digit-enable pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DIV, 50000, clocks a digit stays lit per slot (>=2)
GUARD_CYC, 2, clocks all digits are dark before each lit phase (>=1; covers the decoder's 1-cycle latency)
ACTIVE_LOW_AN, 1, 1 = digit enables active-low, 0 = active-high

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  scan run; low parks the block in IDLE at end of current slot
i_load  in  1  single-cycle strobe; capture iv_value/iv_dp_mask into pending buffer
iv_value  in  4*DIGITS  hex digits, digit 0 = bits [3:0] (least significant)
iv_dp_mask  in  DIGITS  decimal-point request per digit
i_blank  in  1  force all digits dark; scanning and counters continue
ov_nibble  out  4  nibble for current digit, to decoder input
ov_digit_en  out  DIGITS  one-hot digit enable (polarity per ACTIVE_LOW_AN)
o_dp  out  1  decimal point for lit digit, active-low
o_frame  out  1  1-cycle pulse at end of each full scan
o_ack  out  1  1-cycle pulse when pending buffer is committed to active

Behaviour:
- Reset: state IDLE, digit index 0, slot counter 0, active buffer 0, dp active mask 0, pending invalid; ov_nibble=0; ov_digit_en all inactive (all 1 when ACTIVE_LOW_AN=1); o_dp=1; o_frame=0; o_ack=0. Reset mid-scan discards the pending buffer and aborts the slot the same cycle.
- States: IDLE -> GUARD when i_enable=1. GUARD -> ON after GUARD_CYC clocks. ON -> GUARD after DIV clocks, index advances; when i_enable=0 at the end of ON, go to IDLE instead, index reset to 0.
- GUARD: enables inactive, o_dp=1; ov_nibble = active[4*idx +: 4], registered on GUARD entry.
- ON: ov_digit_en asserts only bit idx, unless i_blank=1. o_dp = ~dp_active[idx] while lit, else 1.
- Slot length = GUARD_CYC + DIV clocks; frame = DIGITS slots.
- Index wraps DIGITS-1 -> 0. On the ON->GUARD transition from idx DIGITS-1, o_frame pulses. If pending is valid, active <= pending, pending invalidated and o_ack pulses in the same cycle. The new value is shown starting at digit 0.
- i_load while pending valid: overwrite pending (latest wins); one ack only.
- i_load in the commit cycle: the incoming value is committed directly (bypass) and o_ack pulses; the pending buffer ends invalid.
- i_load while IDLE: held pending; committed at the first GUARD entry from IDLE, with o_ack pulsing.
- i_blank takes effect on the next clock edge (registered); it affects no counter or index.
- Counters sized to $clog2 of max(DIV, GUARD_CYC); no overflow beyond terminal count.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digits above the most significant non-zero nibble of the active value stay dark during their ON phase, with o_dp=1, unless the digit's dp bit is set. Digit 0 is always lit. Slot timing is unchanged.
- Undefined: all digits are lit, including leading zeros.

Test Plan:
All scenarios use DIGITS=4, DIV=4, GUARD_CYC=2.
- Reset, i_enable=1, no load -> ov_nibble=0 per slot; ov_digit_en cycles 1110,1101,1011,0111 (ACTIVE_LOW_AN=1); each digit lit 4 clocks after 2 dark clocks; o_frame pulses every 24 clocks.
- Load iv_value=16'hA3F1 mid-frame -> o_ack and o_frame coincide at frame end; next frame ov_nibble sequence 1,F,3,A; old value shown until commit.
- Two loads (16'h1111 then 16'h2222) inside one frame -> single o_ack; next frame shows 2,2,2,2.
- i_load in the commit cycle with value 16'h0042 -> o_ack that cycle; next frame shows 2,4,0,0 (macro off) or digits 2,3 dark (macro on); iv_dp_mask=4'b0100 keeps digit 2 lit with o_dp=0.
- i_blank=1 for 10 clocks mid-slot -> enables inactive; index and o_frame timing identical to the unblanked run.
- i_rst during ON of digit 2 -> next cycle all enables inactive, o_dp=1, ov_nibble=0, pending discarded, no o_ack. i_enable=0 -> IDLE after the current ON phase.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scan controller: double-buffered hex value, guard-banded digit slots.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens digits above the most significant non-zero nibble.
module seg7_scan_ctrl #(
  parameter int DIGITS        = 4,
  parameter int DIV           = 50000,
  parameter int GUARD_CYC     = 2,
  parameter int ACTIVE_LOW_AN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic [DIGITS-1:0]     iv_dp_mask,
  input  logic                  i_blank,
  output logic [3:0]            ov_nibble,
  output logic [DIGITS-1:0]     ov_digit_en,
  output logic                  o_dp,
  output logic                  o_frame,
  output logic                  o_ack
);

  localparam int MAXC = (DIV > GUARD_CYC) ? DIV : GUARD_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_ON} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;

  logic [4*DIGITS-1:0] r_active, r_pend, w_active_nxt;
  logic [DIGITS-1:0]   r_dp_act, r_pend_dp, w_dp_act_nxt;
  logic                r_pend_vld;

  logic [3:0]          r_nibble, w_nib_nxt;
  logic [DIGITS-1:0]   r_en, w_en_nxt;
  logic                r_dp, w_dp_nxt;
  logic                r_frame, r_ack;

  logic                w_slot_end, w_commit, w_frame, w_guard_entry, w_lit, w_lz_dark;

  assign w_slot_end    = (r_state == S_ON) && (r_cnt == DIV_LAST);
  assign w_frame       = w_slot_end && i_enable && (r_idx == IDX_LAST);
  assign w_commit      = w_frame || ((r_state == S_IDLE) && i_enable);
  assign w_guard_entry = (w_state_nxt == S_GUARD) && (r_state != S_GUARD);

  // State, slot counter and digit index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (i_enable) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (r_cnt == GRD_LAST) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ON: begin
        if (w_slot_end) begin
          w_cnt_nxt = '0;
          if (i_enable) begin
            w_state_nxt = S_GUARD;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // A load arriving on the commit edge bypasses the pending buffer
  always_comb begin
    w_active_nxt = r_active;
    w_dp_act_nxt = r_dp_act;
    if (w_commit) begin
      if (i_load) begin
        w_active_nxt = iv_value;
        w_dp_act_nxt = iv_dp_mask;
      end else if (r_pend_vld) begin
        w_active_nxt = r_pend;
        w_dp_act_nxt = r_pend_dp;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active   <= '0;
      r_dp_act   <= '0;
      r_pend     <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_dp_act <= w_dp_act_nxt;
      if (w_commit) begin
        r_pend_vld <= 1'b0;
      end else if (i_load) begin
        r_pend     <= iv_value;
        r_pend_dp  <= iv_dp_mask;
        r_pend_vld <= 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;

  always_comb begin
    w_msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_active[4*i +: 4] != 4'h0) w_msd = IW'(i);
    end
  end

  assign w_lz_dark = (w_idx_nxt > w_msd) && !r_dp_act[w_idx_nxt];
`else
  assign w_lz_dark = 1'b0;
`endif

  // ON is never entered on a commit edge, so r_active/r_dp_act are settled here
  always_comb begin
    w_lit     = (w_state_nxt == S_ON) && !i_blank && !w_lz_dark;
    w_en_nxt  = w_lit ? (DIGITS'(1) << w_idx_nxt) : '0;
    w_dp_nxt  = w_lit ? ~r_dp_act[w_idx_nxt] : 1'b1;
    w_nib_nxt = w_guard_entry ? w_active_nxt[4*w_idx_nxt +: 4] : r_nibble;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nibble <= 4'h0;
      r_en     <= '0;
      r_dp     <= 1'b1;
      r_frame  <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_nibble <= w_nib_nxt;
      r_en     <= w_en_nxt;
      r_dp     <= w_dp_nxt;
      r_frame  <= w_frame;
      r_ack    <= w_commit && (i_load || r_pend_vld);
    end
  end

  assign ov_nibble   = r_nibble;
  assign ov_digit_en = (ACTIVE_LOW_AN != 0) ? ~r_en : r_en;
  assign o_dp        = r_dp;
  assign o_frame     = r_frame;
  assign o_ack       = r_ack;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, DIV=4, GUARD_CYC=2, active-low enables.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_enable, i_load, i_blank;
  logic [15:0] iv_value;
  logic [3:0]  iv_dp_mask;
  logic [3:0]  ov_nibble;
  logic [3:0]  ov_digit_en;
  logic        o_dp, o_frame, o_ack;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS(4), .DIV(4), .GUARD_CYC(2), .ACTIVE_LOW_AN(1)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_load(i_load),
    .iv_value(iv_value), .iv_dp_mask(iv_dp_mask), .i_blank(i_blank),
    .ov_nibble(ov_nibble), .ov_digit_en(ov_digit_en), .o_dp(o_dp),
    .o_frame(o_frame), .o_ack(o_ack)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          t;
  logic [15:0] exp_act, exp_pend;
  logic [3:0]  exp_dpm, exp_dpm_pend;
  bit          ack_due;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0h want %0h", tag, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // t counts edges since enable; slot = 2 dark + 4 lit clocks, frame = 24 clocks
  task automatic cyc();
    int k, d, p;
    logic lit, dp_e, ack_e, frm_e;
    logic [3:0] en_e, nib_e;
    tick();
    t++;
    k = t % 24;
    d = k / 6;
    p = k % 6;
    ack_e = 1'b0;
    if (k == 0 && ack_due) begin
      exp_act = exp_pend;
      exp_dpm = exp_dpm_pend;
      ack_due = 1'b0;
      ack_e   = 1'b1;
    end
    lit   = (p >= 2) && !i_blank;
    en_e  = lit ? ~(4'b0001 << d) : 4'hF;
    dp_e  = lit ? ~exp_dpm[d] : 1'b1;
    nib_e = exp_act[4*d +: 4];
    frm_e = (k == 0) && (t > 0);
    chk("digit_en", ov_digit_en, en_e);
    chk("nibble", ov_nibble, nib_e);
    chk("dp", o_dp, dp_e);
    chk("frame", o_frame, frm_e);
    chk("ack", o_ack, ack_e);
  endtask

  task automatic run_to(input int tt);
    while (t < tt) cyc();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] m);
    i_load     = 1'b1;
    iv_value   = v;
    iv_dp_mask = m;
    cyc();
    i_load     = 1'b0;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_en"}, ov_digit_en, 4'hF);
    chk({tag, "_dp"}, o_dp, 1'b1);
    chk({tag, "_frame"}, o_frame, 1'b0);
    chk({tag, "_ack"}, o_ack, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_load = 1'b0; i_blank = 1'b0;
    iv_value = '0; iv_dp_mask = '0;
    t = 0;
    exp_act = '0; exp_pend = '0; exp_dpm = '0; exp_dpm_pend = '0; ack_due = 1'b0;
    repeat (3) tick();
    chk_dark("rst");
    chk("rst_nib", ov_nibble, 4'h0);

    // free-running scan of the reset value
    i_rst = 1'b0; i_enable = 1'b1; t = -1;
    run_to(30);

    // single mid-frame load, committed at the frame boundary
    exp_pend = 16'hA3F1; exp_dpm_pend = 4'h0; ack_due = 1'b1;
    load(16'hA3F1, 4'h0);
    run_to(74);

    // two loads in one frame: latest wins, single ack
    exp_pend = 16'h1111; ack_due = 1'b1;
    load(16'h1111, 4'h0);
    run_to(79);
    exp_pend = 16'h2222;
    load(16'h2222, 4'h0);
    run_to(119);

    // load sampled on the commit edge itself
    exp_pend = 16'h0042; exp_dpm_pend = 4'b0100; ack_due = 1'b1;
    load(16'h0042, 4'b0100);
    run_to(152);

    // blank for 10 clocks mid-slot; timing must not move
    i_blank = 1'b1;
    run_to(162);
    i_blank = 1'b0;
    run_to(174);

    // pending value then reset during ON of digit 2
    load(16'h5555, 4'h0);
    run_to(182);
    i_rst = 1'b1;
    tick();
    chk_dark("mid_rst");
    chk("mid_rst_nib", ov_nibble, 4'h0);
    i_rst = 1'b0;
    exp_act = '0; exp_dpm = '0; ack_due = 1'b0;
    t = -1;
    run_to(32);

    // enable drop during ON of digit 1 parks after that slot
    i_enable = 1'b0;
    run_to(35);
    tick(); t++;
    chk_dark("park");
    repeat (3) begin
      tick(); t++;
      chk("idle_en", ov_digit_en, 4'hF);
    end

    // load while idle, committed on the first guard entry
    i_load = 1'b1; iv_value = 16'h0077; iv_dp_mask = 4'h0;
    tick(); t++;
    i_load = 1'b0;
    chk("idle_load_ack", o_ack, 1'b0);
    exp_pend = 16'h0077; exp_dpm_pend = 4'h0; ack_due = 1'b1;
    i_enable = 1'b1; t = -1;
    run_to(47);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
